// File: rtl/posta_tile_stitch_if.sv
// Patch-in / pixel-out bundle for posta_tile_stitch.
// slave = the stitcher's view, master = upstream producer + pixel consumer.
interface posta_tile_stitch_if #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = DATA_W + 6
);
    logic                     valid_in;
    logic                     ready_in;
    logic [ACC_W*4-1:0]       patch_in_flat;
    logic                     pix_valid;
    logic                     pix_ready;
    logic signed [DATA_W-1:0] pix_data;
    logic                     pix_eol;
    logic                     pix_sof;
    logic                     pix_eof;

    modport slave (
        input  valid_in, patch_in_flat, pix_ready,
        output ready_in, pix_valid, pix_data, pix_eol, pix_sof, pix_eof
    );

    modport master (
        output valid_in, patch_in_flat, pix_ready,
        input  ready_in, pix_valid, pix_data, pix_eol, pix_sof, pix_eof
    );
endinterface

// File: rtl/posta_tile_stitch.sv
// Requantizes 2x2 Winograd output patches and restitches them into a raster pixel stream
// through a two-bank strip buffer. Define POSTA_STITCH_RELU_EN to fuse a ReLU before storage.
module posta_tile_stitch #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = DATA_W + 6,
    parameter int IMG_W  = 16,
    parameter int IMG_H  = 16,
    parameter int SHIFT  = 0
) (
    input  logic               clk,
    input  logic               rst,
    posta_tile_stitch_if.slave bus
);
    localparam int TPR    = IMG_W / 2;
    localparam int STRIPS = IMG_H / 2;
    localparam int CW     = (IMG_W > 2)  ? $clog2(IMG_W)  : 1;
    localparam int TCW    = (TPR > 1)    ? $clog2(TPR)    : 1;
    localparam int SW     = (STRIPS > 1) ? $clog2(STRIPS) : 1;
    localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;

    localparam logic [CW-1:0]  COL_LAST   = CW'(IMG_W - 1);
    localparam logic [TCW-1:0] TCOL_LAST  = TCW'(TPR - 1);
    localparam logic [SW-1:0]  STRIP_LAST = SW'(STRIPS - 1);

    localparam logic [ACC_W:0]        RND_U   = (ACC_W+1)'(SHIFT > 0) << RND_SH;
    localparam logic signed [ACC_W:0] RND     = signed'(RND_U);
    localparam logic signed [ACC_W:0] SAT_MAX = signed'({{(ACC_W-DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}});
    localparam logic signed [ACC_W:0] SAT_MIN = signed'({{(ACC_W-DATA_W+2){1'b1}}, {(DATA_W-1){1'b0}}});

    // One extra bit of headroom keeps the half-up rounding add from wrapping.
    function automatic logic signed [DATA_W-1:0] requant(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W:0]    t;
        logic signed [DATA_W-1:0] r;
        t = {a[ACC_W-1], a};
        t = t + RND;
        t = t >>> SHIFT;
        if (t > SAT_MAX)      r = SAT_MAX[DATA_W-1:0];
        else if (t < SAT_MIN) r = SAT_MIN[DATA_W-1:0];
        else                  r = t[DATA_W-1:0];
`ifdef POSTA_STITCH_RELU_EN
        if (r[DATA_W-1]) r = '0;
`else
`endif
        return r;
    endfunction

    logic           wr_bank_q, wr_bank_d;
    logic           rd_bank_q, rd_bank_d;
    logic [TCW-1:0] tcol_q, tcol_d;
    logic [SW-1:0]  strip_q, strip_d;
    logic [1:0]     full_q, full_d;
    logic [1:0]     first_q, first_d;
    logic [1:0]     last_q, last_d;
    logic           rd_row_q, rd_row_d;
    logic [CW-1:0]  rd_col_q, rd_col_d;

    logic signed [DATA_W-1:0] buf_q [2][2][IMG_W];
    logic signed [DATA_W-1:0] qel [4];
    logic [CW-1:0]            wcol0, wcol1;
    logic                     accept, pop, wr_done;

    always_comb begin
        for (int i = 0; i < 4; i++) qel[i] = requant(bus.patch_in_flat[i*ACC_W +: ACC_W]);
    end

    assign bus.ready_in  = ~full_q[wr_bank_q];
    assign bus.pix_valid = full_q[rd_bank_q];
    assign bus.pix_data  = bus.pix_valid ? buf_q[rd_bank_q][rd_row_q][rd_col_q] : '0;
    assign bus.pix_eol   = bus.pix_valid && (rd_col_q == COL_LAST);
    assign bus.pix_sof   = bus.pix_valid && !rd_row_q && (rd_col_q == '0) && first_q[rd_bank_q];
    assign bus.pix_eof   = bus.pix_valid && rd_row_q && (rd_col_q == COL_LAST) && last_q[rd_bank_q];

    assign accept  = bus.valid_in && bus.ready_in;
    assign pop     = bus.pix_valid && bus.pix_ready;
    assign wr_done = accept && (tcol_q == TCOL_LAST);
    assign wcol0   = CW'({tcol_q, 1'b0});
    assign wcol1   = CW'({tcol_q, 1'b1});

    // Write completion and read completion always target different banks, so both may land together.
    always_comb begin
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        tcol_d    = tcol_q;
        strip_d   = strip_q;
        full_d    = full_q;
        first_d   = first_q;
        last_d    = last_q;
        rd_row_d  = rd_row_q;
        rd_col_d  = rd_col_q;
        if (accept) begin
            tcol_d = tcol_q + 1'b1;
            if (wr_done) begin
                tcol_d             = '0;
                full_d[wr_bank_q]  = 1'b1;
                first_d[wr_bank_q] = (strip_q == '0);
                last_d[wr_bank_q]  = (strip_q == STRIP_LAST);
                wr_bank_d          = ~wr_bank_q;
                strip_d            = (strip_q == STRIP_LAST) ? '0 : strip_q + 1'b1;
            end
        end
        if (pop) begin
            rd_col_d = rd_col_q + 1'b1;
            if (rd_col_q == COL_LAST) begin
                rd_col_d = '0;
                rd_row_d = ~rd_row_q;
                if (rd_row_q) begin
                    full_d[rd_bank_q] = 1'b0;
                    rd_bank_d         = ~rd_bank_q;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            tcol_q    <= '0;
            strip_q   <= '0;
            full_q    <= '0;
            first_q   <= '0;
            last_q    <= '0;
            rd_row_q  <= 1'b0;
            rd_col_q  <= '0;
        end else begin
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            tcol_q    <= tcol_d;
            strip_q   <= strip_d;
            full_q    <= full_d;
            first_q   <= first_d;
            last_q    <= last_d;
            rd_row_q  <= rd_row_d;
            rd_col_q  <= rd_col_d;
        end
    end

    // Strip storage carries no reset; stale contents are unreachable once the bank is FREE.
    always_ff @(posedge clk) begin
        if (accept) begin
            buf_q[wr_bank_q][0][wcol0] <= qel[0];
            buf_q[wr_bank_q][0][wcol1] <= qel[1];
            buf_q[wr_bank_q][1][wcol0] <= qel[2];
            buf_q[wr_bank_q][1][wcol1] <= qel[3];
        end
    end
endmodule

// File: tb/tb_posta_tile_stitch.sv
// Randomized bench for posta_tile_stitch: a strip-level pixel queue model predicts
// every pixel, marker, ready_in and pix_valid cycle by cycle.
module tb_posta_tile_stitch;
    localparam int DW     = 16;
    localparam int AW     = 22;
    localparam int IW     = 4;
    localparam int IH     = 4;
    localparam int SH     = 2;
    localparam int TPR    = IW / 2;
    localparam int NPIX   = 2 * IW;
    localparam int FRAME  = TPR * (IH / 2);

    typedef struct {
        longint     d;
        logic [2:0] mk;
    } pix_t;

    logic clk, rst;
    posta_tile_stitch_if #(.DATA_W(DW), .ACC_W(AW)) bus();

    posta_tile_stitch #(.DATA_W(DW), .ACC_W(AW), .IMG_W(IW), .IMG_H(IH), .SHIFT(SH)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    pix_t   exp_q[$];
    longint row_buf[2][IW];
    int     tiles_acc;
    int     n_chk, n_pass;
    int     rdy_mode;
    logic   stall_done;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    // Reference requantization: floor((a + 2^(SH-1)) / 2^SH), clamp, optional ReLU.
    function automatic longint model_q(input longint a);
        longint v, d, q;
        v = a;
        if (SH > 0) begin
            d = longint'(1) << SH;
            v = v + d / 2;
            q = v / d;
            if ((v % d) != 0 && v < 0) q = q - 1;
            v = q;
        end
        if (v > 32767) v = 32767;
        if (v < -32768) v = -32768;
`ifdef POSTA_STITCH_RELU_EN
        if (v < 0) v = 0;
`endif
        return v;
    endfunction

    function automatic logic [4*AW-1:0] pack4(input longint a, input longint b, input longint c, input longint d);
        logic [4*AW-1:0] p;
        p[0*AW +: AW] = a[AW-1:0];
        p[1*AW +: AW] = b[AW-1:0];
        p[2*AW +: AW] = c[AW-1:0];
        p[3*AW +: AW] = d[AW-1:0];
        return p;
    endfunction

    function automatic longint rand_elem();
        logic signed [AW-1:0] x;
        case ($urandom_range(0, 3))
            0: return longint'($urandom_range(0, 40)) - 20;
            1: return longint'($urandom_range(0, 300000)) - 150000;
            2: return ($urandom_range(0, 1) != 0) ? longint'(2**21 - 1) : -longint'(2**21);
            default: begin
                x = $urandom;
                return longint'(x);
            end
        endcase
    endfunction

    // Model step: outputs are compared against the queue front, then handshakes update the model.
    logic signed [AW-1:0] el;
    always @(negedge clk) begin
        if (!rst) begin
            check("ready_in", longint'(bus.ready_in), longint'(exp_q.size() <= NPIX));
            check("pix_valid", longint'(bus.pix_valid), longint'(exp_q.size() > 0));
            if (bus.pix_valid && exp_q.size() > 0) begin
                check("pix_data", longint'(bus.pix_data), exp_q[0].d);
                check("markers", longint'({bus.pix_eol, bus.pix_sof, bus.pix_eof}), longint'(exp_q[0].mk));
                if (bus.pix_ready) void'(exp_q.pop_front());
            end else if (!bus.pix_valid) begin
                check("idle_markers", longint'({bus.pix_eol, bus.pix_sof, bus.pix_eof}), 0);
            end
            if (bus.valid_in && bus.ready_in) begin
                int k, strip;
                k     = tiles_acc % TPR;
                strip = (tiles_acc / TPR) % (IH / 2);
                for (int e = 0; e < 4; e++) begin
                    el = bus.patch_in_flat[e*AW +: AW];
                    row_buf[e / 2][2*k + (e % 2)] = model_q(longint'(el));
                end
                if (k == TPR - 1) begin
                    for (int r = 0; r < 2; r++) begin
                        for (int c = 0; c < IW; c++) begin
                            pix_t p;
                            p.d  = row_buf[r][c];
                            p.mk = {c == IW - 1,
                                    strip == 0 && r == 0 && c == 0,
                                    strip == IH/2 - 1 && r == 1 && c == IW - 1};
                            exp_q.push_back(p);
                        end
                    end
                end
                tiles_acc = (tiles_acc + 1) % FRAME;
            end
        end
    end

    initial begin
        bus.pix_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: bus.pix_ready = 1'b1;
                1: bus.pix_ready = 1'($urandom_range(0, 1));
                2: bus.pix_ready = 1'b0;
                3: bus.pix_ready = ~bus.pix_ready;
                default: ;
            endcase
        end
    end

    task automatic send_tile(input logic [4*AW-1:0] p);
        int   n;
        logic acc;
        n   = 0;
        acc = 1'b0;
        bus.patch_in_flat = p;
        bus.valid_in      = 1'b1;
        while (!acc && n < 300) begin
            @(negedge clk);
            acc = bus.ready_in;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) check("accept_timeout", 0, 1);
        bus.valid_in      = 1'b0;
        bus.patch_in_flat = {$urandom, $urandom, $urandom};
    endtask

    task automatic send_rand_tiles(input int n, input bit gaps);
        for (int t = 0; t < n; t++) begin
            send_tile(pack4(rand_elem(), rand_elem(), rand_elem(), rand_elem()));
            if (gaps && $urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        check("drain_timeout", longint'(exp_q.size()), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        tiles_acc = 0;
        rdy_mode = 0;
        stall_done = 1'b0;
        rst = 1'b1;
        bus.valid_in = 1'b0;
        bus.patch_in_flat = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_pix_valid", longint'(bus.pix_valid), 0);
        check("rst_ready_in", longint'(bus.ready_in), 1);
        check("rst_pix_data", longint'(bus.pix_data), 0);
        check("rst_markers", longint'({bus.pix_eol, bus.pix_sof, bus.pix_eof}), 0);
        rst = 1'b0;

        // Back-to-back ordered frame, elements 1..16.
        for (int t = 0; t < FRAME; t++) send_tile(pack4(4*t+1, 4*t+2, 4*t+3, 4*t+4));
        wait_drain();

        // Rounding and saturation corners, plus a negative value for the ReLU path.
        send_tile(pack4(6, -6, 2**21 - 1, -(2**21)));
        send_tile(pack4(-7, 0, 1, 2));
        send_rand_tiles(TPR, 1'b0);
        wait_drain();

        // Three strips against a stalled consumer.
        rdy_mode = 2;
        fork
            begin
                send_rand_tiles(3 * TPR, 1'b0);
                stall_done = 1'b1;
            end
        join_none
        repeat (25) @(posedge clk);
        @(negedge clk);
        check("stall_ready_low", longint'(bus.ready_in), 0);
        @(posedge clk);
        #1;
        rdy_mode = 0;
        for (int n = 0; n < 300 && !stall_done; n++) @(posedge clk);
        check("stall_sender_done", longint'(stall_done), 1);
        #1;
        wait_drain();
        if (tiles_acc != 0) send_rand_tiles(FRAME - tiles_acc, 1'b0);
        wait_drain();

        // Alternating ready across bank switches.
        rdy_mode = 3;
        send_rand_tiles(2 * FRAME, 1'b0);
        wait_drain();

        // Random backpressure with random upstream gaps.
        rdy_mode = 1;
        send_rand_tiles(5 * FRAME, 1'b1);
        wait_drain();

        // Reset with five pixels of a strip still undrained.
        rdy_mode = 4;
        bus.pix_ready = 1'b0;
        send_rand_tiles(TPR, 1'b0);
        @(posedge clk);
        #1;
        bus.pix_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("pre_rst_left", longint'(exp_q.size()), 5);
        rst = 1'b1;
        exp_q.delete();
        tiles_acc = 0;
        #1;
        check("midrst_pix_valid", longint'(bus.pix_valid), 0);
        check("midrst_ready_in", longint'(bus.ready_in), 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        rdy_mode = 0;
        send_rand_tiles(FRAME, 1'b1);
        wait_drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
